// File: rtl/skin_bbox_tracker.sv
// Skin-mask bounding-box tracker: accumulates the min/max column and row and the
// pixel count of nonzero mask pixels over a raster frame, then reports them once.
module skin_bbox_tracker #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int MIN_COUNT = 64
) (
  input  logic        iclk,
  input  logic        irst_n,
  input  logic        iSOF,
  input  logic        iDVAL,
  input  logic [15:0] iDATA,
  output logic [9:0]  oX_MIN,
  output logic [9:0]  oX_MAX,
  output logic [9:0]  oY_MIN,
  output logic [9:0]  oY_MAX,
  output logic [18:0] oCOUNT,
  output logic        oFOUND,
  output logic        oRVAL
);

  localparam logic [9:0]  X_LAST  = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_LAST  = 10'(V_ACTIVE - 1);
  localparam logic [18:0] CNT_MIN = 19'(MIN_COUNT);

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [9:0]  xmin;
    logic [9:0]  xmax;
    logic [9:0]  ymin;
    logic [9:0]  ymax;
    logic [18:0] cnt;
  } acc_t;

  state_t r_state, w_state_nxt;
  acc_t   r_acc, w_acc;
  logic   w_take;

  logic [9:0]  r_xmin_o, r_xmax_o, r_ymin_o, r_ymax_o;
  logic [18:0] r_cnt_o;
  logic        r_found_o, r_rval;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc;
    end
  end

  // iSOF wins in every state: clear first, then the same cycle's pixel lands at (0,0).
  always_comb begin
    w_state_nxt = r_state;
    w_acc       = r_acc;
    w_take      = 1'b0;
    if (iSOF) begin
      w_state_nxt = ACCUM;
      w_acc       = '0;
      w_acc.xmin  = '1;
      w_acc.ymin  = '1;
      w_take      = iDVAL;
    end else begin
      case (r_state)
        ACCUM:   w_take = iDVAL;
        REPORT:  w_state_nxt = IDLE;
        default: w_take = 1'b0;
      endcase
    end
    if (w_take) begin
      if (|iDATA) begin
        if (w_acc.cnt != '1)      w_acc.cnt  = w_acc.cnt + 1'b1;
        if (w_acc.x < w_acc.xmin) w_acc.xmin = w_acc.x;
        if (w_acc.x > w_acc.xmax) w_acc.xmax = w_acc.x;
        if (w_acc.y < w_acc.ymin) w_acc.ymin = w_acc.y;
        if (w_acc.y > w_acc.ymax) w_acc.ymax = w_acc.y;
      end
      if (w_acc.x == X_LAST) begin
        w_acc.x = '0;
        if (w_acc.y == Y_LAST) begin
          w_acc.y     = '0;
          w_state_nxt = REPORT;
        end else begin
          w_acc.y = w_acc.y + 1'b1;
        end
      end else begin
        w_acc.x = w_acc.x + 1'b1;
      end
    end
  end

  // Result registers load from the accumulator as it stood on entry to REPORT.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_xmin_o  <= '0;
      r_xmax_o  <= '0;
      r_ymin_o  <= '0;
      r_ymax_o  <= '0;
      r_cnt_o   <= '0;
      r_found_o <= 1'b0;
      r_rval    <= 1'b0;
    end else begin
      r_rval <= (r_state == REPORT);
      if (r_state == REPORT) begin
        if (r_acc.cnt == '0) begin
          r_xmin_o <= '0;
          r_xmax_o <= '0;
          r_ymin_o <= '0;
          r_ymax_o <= '0;
        end else begin
          r_xmin_o <= r_acc.xmin;
          r_xmax_o <= r_acc.xmax;
          r_ymin_o <= r_acc.ymin;
          r_ymax_o <= r_acc.ymax;
        end
        r_cnt_o   <= r_acc.cnt;
        r_found_o <= (r_acc.cnt != '0) && (r_acc.cnt >= CNT_MIN);
      end
    end
  end

  assign oX_MIN = r_xmin_o;
  assign oX_MAX = r_xmax_o;
  assign oY_MIN = r_ymin_o;
  assign oY_MAX = r_ymax_o;
  assign oCOUNT = r_cnt_o;
  assign oFOUND = r_found_o;
  assign oRVAL  = r_rval;

endmodule

// File: tb/tb_skin_bbox_tracker.sv
// Bench for skin_bbox_tracker: random mask frames with a per-frame reference
// model feeding a scoreboard; the monitor checks every report and the held outputs.
module tb_skin_bbox_tracker;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int MC = 2;

  logic        iclk = 1'b0, irst_n = 1'b0, iSOF = 1'b0, iDVAL = 1'b0;
  logic [15:0] iDATA = '0;
  logic [9:0]  oX_MIN, oX_MAX, oY_MIN, oY_MAX;
  logic [18:0] oCOUNT;
  logic        oFOUND, oRVAL;

  always #5 iclk = ~iclk;

  skin_bbox_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_COUNT(MC)) dut (
    .iclk(iclk), .irst_n(irst_n), .iSOF(iSOF), .iDVAL(iDVAL), .iDATA(iDATA),
    .oX_MIN(oX_MIN), .oX_MAX(oX_MAX), .oY_MIN(oY_MIN), .oY_MAX(oY_MAX),
    .oCOUNT(oCOUNT), .oFOUND(oFOUND), .oRVAL(oRVAL)
  );

  typedef struct {
    int x0, x1, y0, y1, cnt, found, cyc;
  } exp_t;

  int   cyc = 0;
  bit   img[V][H];
  exp_t q[$];
  exp_t held, mon_e;
  int   n_chk = 0, n_fail = 0;
  bit   stim_done = 1'b0;

  always @(posedge iclk) cyc <= cyc + 1;

  // Reference: scan the whole mask image and derive the report directly.
  function automatic exp_t model();
    exp_t e;
    e.cnt = 0; e.x0 = H; e.x1 = -1; e.y0 = V; e.y1 = -1;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        if (img[y][x]) begin
          e.cnt++;
          if (x < e.x0) e.x0 = x;
          if (x > e.x1) e.x1 = x;
          if (y < e.y0) e.y0 = y;
          if (y > e.y1) e.y1 = y;
        end
    if (e.cnt == 0) begin
      e.x0 = 0; e.x1 = 0; e.y0 = 0; e.y1 = 0;
    end
    e.found = (e.cnt >= MC) ? 1 : 0;
    e.cyc   = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input longint act, input longint expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  always @(negedge iclk) begin
    if (!irst_n) held = '{default: 0};
    if (oRVAL) begin
      if (q.size() == 0) chk("spurious_rval", 1, 0);
      else begin
        mon_e = q.pop_front();
        chk("rval_cycle", cyc, mon_e.cyc);
        chk("x_min", oX_MIN, mon_e.x0);
        chk("x_max", oX_MAX, mon_e.x1);
        chk("y_min", oY_MIN, mon_e.y0);
        chk("y_max", oY_MAX, mon_e.y1);
        chk("count", oCOUNT, mon_e.cnt);
        chk("found", oFOUND, mon_e.found);
        held = mon_e;
      end
    end else begin
      chk("hold_box", {oX_MIN, oX_MAX, oY_MIN, oY_MAX},
          {10'(held.x0), 10'(held.x1), 10'(held.y0), 10'(held.y1)});
      chk("hold_cnt", {oCOUNT, oFOUND}, {19'(held.cnt), 1'(held.found)});
    end
    if (cyc > 20000) begin
      n_fail++;
      $display("FAIL timeout: got cycle %0d expected under 20000", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "timeout");
    end
    if (stim_done) begin
      chk("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  // mode 0: separate iSOF cycle, 1: iSOF with first pixel, 2: no iSOF.
  task automatic frame(input int mode, input int gmax, input int stop_after, input bit push);
    exp_t e;
    if (mode == 0) begin
      iSOF = 1'b1; iDVAL = 1'b0; iDATA = 16'($urandom);
      tick();
      iSOF = 1'b0;
    end
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        if (stop_after >= 0 && y * H + x == stop_after) return;
        repeat ($urandom_range(0, gmax)) begin
          iDVAL = 1'b0; iDATA = 16'($urandom);
          tick();
        end
        iDVAL = 1'b1;
        iDATA = img[y][x] ? 16'($urandom_range(1, 65535)) : 16'h0;
        iSOF  = (mode == 1 && x == 0 && y == 0);
        tick();
        iSOF = 1'b0; iDVAL = 1'b0;
      end
    if (push) begin
      e     = model();
      e.cyc = cyc + 1;
      q.push_back(e);
    end
  endtask

  task automatic fill(input int dens);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        img[y][x] = ($urandom_range(0, 99) < dens);
  endtask

  initial begin
    repeat (3) tick();
    irst_n = 1'b1;
    repeat (2) tick();

    fill(0);
    for (int y = 1; y <= 2; y++)
      for (int x = 2; x <= 4; x++) img[y][x] = 1'b1;
    frame(0, 0, -1, 1'b1);
    repeat (2) tick();

    fill(0);
    frame(0, 0, -1, 1'b1);

    fill(0);
    img[3][7] = 1'b1;
    frame(0, 1, -1, 1'b1);

    fill(40);
    frame(0, 0, 10, 1'b0);
    frame(0, 0, -1, 1'b1);

    fill(30);
    frame(0, 0, -1, 1'b1);
    frame(1, 3, -1, 1'b1);
    frame(1, 0, -1, 1'b1);

    fill(50);
    frame(1, 2, 7, 1'b0);
    frame(1, 2, -1, 1'b1);

    for (int i = 0; i < 6; i++) begin
      fill($urandom_range(0, 100));
      frame(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), -1, 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end

    fill(60);
    frame(0, 1, 10, 1'b0);
    irst_n = 1'b0;
    repeat (2) tick();
    irst_n = 1'b1;
    frame(2, 1, -1, 1'b0);
    repeat (4) tick();

    fill(20);
    frame(1, 1, -1, 1'b1);
    repeat (5) tick();
    stim_done = 1'b1;
  end

endmodule

// File: doc/skin_bbox_tracker.md
SKIN_BBOX_TRACKER -- requirements
Module: skin_bbox_tracker

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line.
REQ-002 The block SHALL have parameter V_ACTIVE, default 480, meaning active lines per frame.
REQ-003 The block SHALL have parameter MIN_COUNT, default 64, meaning the minimum skin-pixel count that asserts oFOUND.
REQ-004 The block SHALL have port iclk, input, 1 bit: clock, rising edge.
REQ-005 The block SHALL have port irst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port iSOF, input, 1 bit: one-cycle start-of-frame pulse.
REQ-007 The block SHALL have port iDVAL, input, 1 bit: mask pixel valid.
REQ-008 The block SHALL have port iDATA, input, 16 bits: skin mask pixel from the skin detector; any nonzero value is skin.
REQ-009 The block SHALL have ports oX_MIN and oX_MAX, output, 10 bits each: bounding-box column limits.
REQ-010 The block SHALL have ports oY_MIN and oY_MAX, output, 10 bits each: bounding-box row limits.
REQ-011 The block SHALL have port oCOUNT, output, 19 bits: skin pixels in the frame.
REQ-012 The block SHALL have port oFOUND, output, 1 bit: high when oCOUNT >= MIN_COUNT.
REQ-013 The block SHALL have port oRVAL, output, 1 bit: one-cycle result-valid pulse.

Function
REQ-014 The block SHALL implement three states: IDLE, ACCUM and REPORT.
REQ-015 IDLE transitions: iSOF=1 -> ACCUM. All iDVAL in IDLE is ignored.
REQ-016 On the iSOF edge, x, y, count, min and max SHALL be cleared. x_min/y_min clear to all-ones; x_max/y_max clear to 0.
REQ-017 iDVAL=1 in the same cycle as iSOF SHALL be accepted as pixel (0,0) of the new frame.
REQ-018 In ACCUM, each accepted pixel SHALL advance x. At x=H_ACTIVE-1, x wraps to 0 and y increments.
REQ-019 For a skin pixel, the block SHALL increment count, saturating at 2^19-1, and update min/max with the current x,y.
REQ-020 ACCUM transitions: when the pixel at x=H_ACTIVE-1, y=V_ACTIVE-1 is accepted at edge N, the state goes to REPORT.
REQ-021 At edge N+1, the outputs SHALL be updated with the complete frame result including the last pixel, and oRVAL=1 for exactly that one cycle.
REQ-022 REPORT transitions: REPORT -> IDLE at the next edge, unless iSOF=1, in which case REPORT -> ACCUM with a fresh clear.
REQ-023 iSOF in ACCUM SHALL restart accumulation, discard the partial frame and produce no oRVAL.
REQ-024 Empty frame (count=0): oX_MIN, oX_MAX, oY_MIN, oY_MAX SHALL report 0, oCOUNT=0 and oFOUND=0.
REQ-025 0 < count < MIN_COUNT: the raw box and count SHALL be reported with oFOUND=0.
REQ-026 Outputs other than oRVAL SHALL hold their values until the next report.
REQ-027 iDVAL=0 cycles SHALL not advance x/y; gaps of any length are legal.

Reset
REQ-028 While irst_n=0, state SHALL be IDLE, all outputs 0, and internal counters 0.
REQ-029 Reset mid-frame SHALL abandon the frame. After release, no oRVAL occurs until a full frame following a new iSOF.

Verification
REQ-030 Single skin block (H=8, V=4, MIN_COUNT=2): iSOF, then a frame with skin at x=2..4, y=1..2 -> one oRVAL; box (2,4,1,2), oCOUNT=6, oFOUND=1.
REQ-031 All-zero frame -> oRVAL once; all box outputs 0, oCOUNT=0, oFOUND=0.
REQ-032 Single skin pixel at (7,3) with MIN_COUNT=2 -> box (7,7,3,3), oCOUNT=1, oFOUND=0; the last pixel is included.
REQ-033 iSOF after 10 pixels, then a full frame -> exactly one oRVAL, reflecting only the second frame.
REQ-034 Random iDVAL gaps plus iSOF coincident with the first pixel -> result identical to the gap-free run; oRVAL one cycle after the last pixel.
REQ-035 irst_n low mid-frame, then released, with the frame continuing without iSOF -> no oRVAL, outputs stay 0.
